// File: rtl/bist_pkg.sv
// Shared types and defaults for the BIST sequencer: FSM state encoding and
// the Moore decode of each state onto the control outputs.
package bist_pkg;

  localparam int DEF_SIG_WIDTH = 4;
  localparam int DEF_CNT_WIDTH = 8;
  localparam logic [DEF_SIG_WIDTH-1:0] DEF_GOLDEN_SIG = 4'b0000;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RUN,
    FLUSH,
    COMPARE,
    DONE
  } state_t;

  typedef struct packed {
    logic test_mode;
    logic lfsr_load;
    logic lfsr_en;
    logic misr_clear;
    logic busy;
    logic done;
  } ctl_t;

  function automatic ctl_t decode_state(input state_t s);
    ctl_t c;
    c = '0;
    unique case (s)
      INIT: begin
        c.test_mode  = 1'b1;
        c.lfsr_load  = 1'b1;
        c.misr_clear = 1'b1;
        c.busy       = 1'b1;
      end
      RUN: begin
        c.test_mode = 1'b1;
        c.lfsr_en   = 1'b1;
        c.busy      = 1'b1;
      end
      FLUSH, COMPARE: begin
        c.test_mode = 1'b1;
        c.busy      = 1'b1;
      end
      DONE:    c.done = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/bist_delay_line.sv
// DEPTH-cycle shift register used to align MISR compaction with the CUT
// pipeline; a plain wire when DEPTH is zero.
module bist_delay_line #(
  parameter int DEPTH = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic din,
  output logic dout
);

  if (DEPTH == 0) begin : g_pass
    logic unused_ctl;
    assign unused_ctl = &{1'b0, clock, reset, clear};
    assign dout = din;
  end else begin : g_shift
    logic [DEPTH-1:0] sr_p0;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        sr_p0 <= '0;
      end else if (clear) begin
        sr_p0 <= '0;
      end else begin
        sr_p0 <= (sr_p0 << 1) | DEPTH'(din);
      end
    end

    assign dout = sr_p0[DEPTH-1];
  end

endmodule

// File: rtl/bist_controller.sv
// BIST sequencer: seeds the LFSR, clears the MISR, runs a fixed pattern
// count, flushes the CUT pipeline and compares the final signature.
module bist_controller
  import bist_pkg::*;
#(
  parameter int N_PATTERNS = 15,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int SIG_WIDTH  = DEF_SIG_WIDTH,
  parameter int LATENCY    = 1,
  parameter logic [SIG_WIDTH-1:0] GOLDEN_SIG = SIG_WIDTH'(DEF_GOLDEN_SIG)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [SIG_WIDTH-1:0] signature,
  output logic                 test_mode,
  output logic                 lfsr_load,
  output logic                 lfsr_en,
  output logic                 misr_clear,
  output logic                 misr_en,
  output logic                 busy,
  output logic                 done,
  output logic                 pass
);

  if (N_PATTERNS < 1 || longint'(N_PATTERNS) >= (longint'(1) << CNT_WIDTH)) begin : g_bad_np
    $error("bist_controller: N_PATTERNS out of range for CNT_WIDTH");
  end
  if (LATENCY < 0 || longint'(LATENCY) >= (longint'(1) << CNT_WIDTH)) begin : g_bad_lat
    $error("bist_controller: LATENCY out of range for CNT_WIDTH");
  end

  localparam logic [CNT_WIDTH-1:0] CNT_RUN   = CNT_WIDTH'(N_PATTERNS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_FLUSH = CNT_WIDTH'(LATENCY - 1);

  state_t               state;
  state_t               state_next;
  ctl_t                 ctl_next;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 dly_clear;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = INIT;
      INIT:    state_next = abort ? IDLE : RUN;
      RUN: begin
        if (abort) state_next = IDLE;
        else if (cnt == '0) state_next = (LATENCY > 0) ? FLUSH : COMPARE;
      end
      FLUSH: begin
        if (abort) state_next = IDLE;
        else if (cnt == '0) state_next = COMPARE;
      end
      COMPARE: state_next = abort ? IDLE : DONE;
      DONE:    if (start) state_next = INIT;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they are glitch-free Moore.
  assign ctl_next  = decode_state(state_next);
  assign dly_clear = (state_next == IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      test_mode  <= 1'b0;
      lfsr_load  <= 1'b0;
      lfsr_en    <= 1'b0;
      misr_clear <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      state      <= state_next;
      test_mode  <= ctl_next.test_mode;
      lfsr_load  <= ctl_next.lfsr_load;
      lfsr_en    <= ctl_next.lfsr_en;
      misr_clear <= ctl_next.misr_clear;
      busy       <= ctl_next.busy;
      done       <= ctl_next.done;

      if (state_next == INIT) begin
        cnt <= CNT_RUN;
      end else if (state == RUN && state_next == FLUSH) begin
        cnt <= CNT_FLUSH;
      end else if (state_next == state && (state == RUN || state == FLUSH)) begin
        cnt <= cnt - 1'b1;
      end else if (state_next == IDLE) begin
        cnt <= '0;
      end

      if (state == COMPARE && state_next == DONE) begin
        pass <= (signature == GOLDEN_SIG);
      end else if (state_next != DONE) begin
        pass <= 1'b0;
      end
    end
  end

  // lfsr_en is delayed by the CUT depth so compaction sees matching responses.
  bist_delay_line #(
    .DEPTH(LATENCY)
  ) u_misr_dly (
    .clock(clock),
    .reset(reset),
    .clear(dly_clear),
    .din  (lfsr_en),
    .dout (misr_en)
  );

endmodule

// File: tb/tb_bist_controller.sv
// Directed bench for bist_controller: two configurations, cycle-accurate
// output model and a pass/fail scoreboard.
module tb_bist_controller;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic       start_a, abort_a;
  logic [3:0] sig_a;
  logic       tm_a, ld_a, le_a, mc_a, me_a, busy_a, done_a, pass_a;
  logic       start_b, abort_b;
  logic [3:0] sig_b;
  logic       tm_b, ld_b, le_b, mc_b, me_b, busy_b, done_b, pass_b;

  bist_controller #(
    .N_PATTERNS(7), .CNT_WIDTH(8), .SIG_WIDTH(4), .LATENCY(1), .GOLDEN_SIG(4'hA)
  ) dut_a (
    .clock(clock), .reset(reset), .start(start_a), .abort(abort_a),
    .signature(sig_a), .test_mode(tm_a), .lfsr_load(ld_a), .lfsr_en(le_a),
    .misr_clear(mc_a), .misr_en(me_a), .busy(busy_a), .done(done_a), .pass(pass_a)
  );

  bist_controller #(
    .N_PATTERNS(4), .CNT_WIDTH(8), .SIG_WIDTH(4), .LATENCY(0), .GOLDEN_SIG(4'hA)
  ) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .abort(abort_b),
    .signature(sig_b), .test_mode(tm_b), .lfsr_load(ld_b), .lfsr_en(le_b),
    .misr_clear(mc_b), .misr_en(me_b), .busy(busy_b), .done(done_b), .pass(pass_b)
  );

  int   total = 0;
  int   bad   = 0;
  logic q_a[$];
  logic q_b[$];
  logic last_a, last_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {test_mode, lfsr_load, lfsr_en, misr_clear, misr_en, busy, done}
  function automatic logic [6:0] outs(input int sel);
    if (sel == 0) return {tm_a, ld_a, le_a, mc_a, me_a, busy_a, done_a};
    return {tm_b, ld_b, le_b, mc_b, me_b, busy_b, done_b};
  endfunction

  function automatic logic pass_of(input int sel);
    return (sel == 0) ? pass_a : pass_b;
  endfunction

  // Expected outputs k cycles after the edge that sampled start.
  function automatic logic [6:0] model(input int n, input int l, input int k);
    logic bsy, ld, len, men, dn;
    bsy = (k <= n + l + 1);
    ld  = (k == 0);
    len = (k >= 1) && (k <= n);
    men = (k >= l + 1) && (k <= n + l);
    dn  = (k >= n + l + 2);
    return {bsy, ld, len, ld, men, bsy, dn};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_step(input int sel, input int n, input int l, input int k, input string tag);
    logic e;
    check($sformatf("%s_k%0d_outs", tag, k), 32'(outs(sel)), 32'(model(n, l, k)));
    if (k == n + l + 2) begin
      if (sel == 0) begin
        check($sformatf("%s_sb_has_entry", tag), 32'(q_a.size() != 0), 32'd1);
        last_a = (q_a.size() != 0) ? q_a.pop_front() : 1'bx;
      end else begin
        check($sformatf("%s_sb_has_entry", tag), 32'(q_b.size() != 0), 32'd1);
        last_b = (q_b.size() != 0) ? q_b.pop_front() : 1'bx;
      end
    end
    e = (k < n + l + 2) ? 1'b0 : ((sel == 0) ? last_a : last_b);
    check($sformatf("%s_k%0d_pass", tag, k), 32'(pass_of(sel)), 32'(e));
  endtask

  // Walk samples kfrom..kto; the caller has already stepped to kfrom.
  task automatic run(input int sel, input int n, input int l, input int kfrom, input int kto,
                     input bit hold, input string tag);
    for (int k = kfrom; k <= kto; k++) begin
      check_step(sel, n, l, k, tag);
      if (!hold) begin
        if (sel == 0) start_a = 1'b0;
        else start_b = 1'b0;
      end
      if (k == n + l + 2) begin
        if (sel == 0) sig_a = ~sig_a;
        else sig_b = ~sig_b;
      end
      if (k < kto) tick();
    end
  endtask

  task automatic check_idle(input int sel, input string tag);
    check({tag, "_outs"}, 32'(outs(sel)), 32'd0);
    check({tag, "_pass"}, 32'(pass_of(sel)), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    start_a = 1'b0; abort_a = 1'b0; sig_a = 4'h0;
    start_b = 1'b0; abort_b = 1'b0; sig_b = 4'h0;
    reset = 1'b1;
    #3;
    check_idle(0, "rst_a_active");
    check_idle(1, "rst_b_active");
    #9 reset = 1'b0;
    tick();
    check_idle(0, "rst_a_idle");
    check_idle(1, "rst_b_idle");

    // Nominal run with matching signature
    sig_a = 4'hA; start_a = 1'b1; q_a.push_back(1'b1);
    tick();
    run(0, 7, 1, 0, 12, 1'b0, "t1");

    // Mismatching signature, then a re-run from DONE
    sig_a = 4'h3; start_a = 1'b1; q_a.push_back(1'b0);
    tick();
    run(0, 7, 1, 0, 11, 1'b0, "t2");
    sig_a = 4'hA; start_a = 1'b1; q_a.push_back(1'b1);
    tick();
    run(0, 7, 1, 0, 10, 1'b0, "t2b");

    // Zero latency: no FLUSH, misr_en follows lfsr_en
    sig_b = 4'hA; start_b = 1'b1; q_b.push_back(1'b1);
    tick();
    run(1, 4, 0, 0, 8, 1'b0, "t3");

    // Abort during the third RUN cycle
    sig_a = 4'hA; start_a = 1'b1; q_a.push_back(1'b1);
    tick();
    run(0, 7, 1, 0, 3, 1'b0, "t4");
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    void'(q_a.pop_back());
    check_idle(0, "t4_abort");
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle(0, $sformatf("t4_idle%0d", i));
    end
    // start and abort together in IDLE: start wins
    start_a = 1'b1; abort_a = 1'b1; q_a.push_back(1'b1);
    tick();
    abort_a = 1'b0;
    run(0, 7, 1, 0, 10, 1'b0, "t4b");

    // Asynchronous reset in the FLUSH cycle, between edges
    sig_a = 4'hA; start_a = 1'b1; q_a.push_back(1'b1);
    tick();
    run(0, 7, 1, 0, 8, 1'b0, "t5");
    #2 reset = 1'b1;
    #1;
    check_idle(0, "t5_async");
    #2 reset = 1'b0;
    void'(q_a.pop_back());
    tick();
    check_idle(0, "t5_after");
    check_idle(1, "t5_after_b");

    // start held high: no restart while busy, restart from DONE
    sig_a = 4'hA; start_a = 1'b1; q_a.push_back(1'b1);
    tick();
    run(0, 7, 1, 0, 10, 1'b1, "t6");
    sig_a = 4'hA; q_a.push_back(1'b1);
    tick();
    run(0, 7, 1, 0, 2, 1'b1, "t6b");
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    start_a = 1'b0;
    void'(q_a.pop_back());
    check_idle(0, "t6_abort");
    tick();
    check_idle(0, "t6_idle");
    check($sformatf("sb_drained"), 32'(q_a.size() + q_b.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
